// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial test/config link (PISO transmitter side).
// SERIAL_PARITY_EN appends an even-parity bit after the data bits of every frame.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int frame_len(input int width);
`ifdef SERIAL_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Enable-gated up-counter with synchronous clear; tc flags the terminal value LAST.
// Holds at LAST instead of wrapping, so the frame index can never run past the last bit.
module bit_counter #(
  parameter int CNT_W = 4,
  parameter int LAST  = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == CNT_W'(LAST));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first, one bit per enabled cycle; first bit 1 cycle after load.
// Optional SERIAL_PARITY_EN: even parity of the word is sent as a trailing frame bit.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  input  logic [WIDTH-1:0] i_DATA,
  output logic             o_READY,
  input  logic             i_EN,
  output logic             o_SO,
  output logic             o_SO_VALID,
  output logic             o_DONE
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = cnt_width(WIDTH);

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic                 done_q, done_d;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 cnt_tc;

  bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (FRAME_LEN - 1)
  ) u_bit_counter (
    .clk (i_CLK),
    .rst (i_RST),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_VALID) begin
`ifdef SERIAL_PARITY_EN
          shreg_d = {^i_DATA, i_DATA};
`else
          shreg_d = i_DATA;
`endif
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // With i_EN low nothing moves, so the current bit stays on o_SO.
        if (i_EN) begin
          shreg_d = shreg_q >> 1;
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  assign o_READY    = (state_q == IDLE);
  assign o_SO_VALID = (state_q == SHIFT);
  assign o_SO       = (state_q == SHIFT) & shreg_q[0];
  assign o_DONE     = done_q;

endmodule
